apu_reg_writer: RTL and testbench
=================================

Name: apu_reg_writer

Overview:
- Host-side register writer for the two APU pulse channels.
- Decodes a framed byte stream from the UART receiver (one-cycle byte strobes) into register writes.
- Drives the channels' reg_0..reg_3 buses and per-channel reg_change toggles; each channel compares reg_change against its own copy to restart length, envelope and sequencer.
- Sits between the UART receiver and the two pulse channel instances, in the apu_clk domain.

Parameters:
- TIMEOUT, 5000, apu_clk cycles allowed between bytes of a frame before the parser abandons it.
- TMR_W, 13, width of the timeout counter; must satisfy 2**TMR_W > TIMEOUT.

Ports:
- apu_clk  in  1  APU clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, at most one byte per cycle.
- p1_reg_0 .. p1_reg_3  out  8 each  pulse channel 1 registers (APU $4000-$4003).
- p2_reg_0 .. p2_reg_3  out  8 each  pulse channel 2 registers (APU $4004-$4007).
- p1_change  out  1  toggles on each write to p1_reg_3.
- p2_change  out  1  toggles on each write to p2_reg_3.
- busy  out  1  high while a frame is open (state WAIT_DATA).
- err_count  out  4  count of rejected header bytes; saturates at 15.

Behaviour:
- Reset (async assert, sync release): all eight registers = 8'h00, p1_change = p2_change = 0, err_count = 0, busy = 0, state = IDLE, timeout counter = 0.
- Header byte format:
  - [7:5] sync = 3'b101.
  - [4] auto-increment.
  - [3] reserved, ignored.
  - [2:0] register address: 0-3 = pulse 1 reg 0-3; 4-7 = pulse 2 reg 0-3.
- IDLE, rx_valid with sync match: latch addr and auto-increment, clear timer, go to WAIT_DATA.
- IDLE, rx_valid with sync mismatch: byte dropped, err_count += 1 (saturating), stay in IDLE.
- WAIT_DATA, rx_valid: rx_data is a data byte; all 8 bits are data and no sync check is made.
  - The target register takes rx_data at this same edge, so the new value is visible on the next cycle (1-cycle write latency from the strobe).
  - If addr==3, p1_change toggles at the same edge; if addr==7, p2_change toggles at the same edge. Writes to any other address leave both toggles unchanged.
  - Auto-increment=0: return to IDLE.
  - Auto-increment=1: addr <= addr+1 with 3-bit wrap (7 -> 0), timer cleared, stay in WAIT_DATA.
- WAIT_DATA, no rx_valid: timer += 1. When the timer reaches TIMEOUT-1, go to IDLE with no register write and no err_count change.
- rx_valid takes priority over timeout expiry in the same cycle: the byte is accepted as data.
- busy = 1 exactly while state == WAIT_DATA.
- A burst starting at addr 0 with 8 bytes writes p1 reg 0-3 then p2 reg 0-3 and toggles each change bit once. A 9th byte wraps to addr 0.
- Toggle-based change signalling: consumers on slower strobes can miss a double toggle between their sampling points. Hosts must space reg_3 writes to the same channel by at least one half-frame. This block does not enforce that spacing.
- Reset mid-frame: the frame is discarded and all registers revert to 8'h00.
- No combinational path from rx_* to any output; every output is a flop or derived from one (busy = state decode).

Decomposition:
- Package apu_pkg:
  - constant for sync pattern 3'b101;
  - address constants ADDR_P1_R3=3, ADDR_P2_R3=7;
  - 1-bit state enum {IDLE, WAIT_DATA};
  - header field bit-position constants.
- Sub-module apu_frame_timer (TMR_W-bit counter):
  - inputs clear/enable;
  - output expired at TIMEOUT-1;
  - reused by other host-link parsers.
- The register bank and toggles stay in the parent.

Test Plan:
- Reset, then header 8'hA3, data 8'h5C -> p1_reg_3=8'h5C one cycle after the data strobe; p1_change 0->1; p2_change stays 0; busy high between the two strobes only.
- Header 8'hB0 (auto-inc, addr 0), then 8 data bytes 8'h11..8'h88 -> p1_reg_0..3 = 11,22,33,44; p2_reg_0..3 = 55,66,77,88; each change bit toggles once; a 9th byte 8'h99 overwrites p1_reg_0.
- Bytes 8'h00, 8'hFF, 8'h43 in IDLE -> no register change; err_count=3. Then 20 more bad bytes -> err_count holds at 15.
- Header 8'hA1, wait TIMEOUT cycles, then byte 8'hA0 -> no write to p1_reg_1; 8'hA0 is parsed as a new header (addr 0) and busy goes high.
- Data strobe arrives on the exact timeout-expiry cycle -> byte written, state IDLE.
- rst_n pulsed low asynchronously between header and data -> all regs 8'h00, toggles 0, busy 0 immediately; the following data byte is treated as a header.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and types for the APU host register writer.
package apu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned ERR_W    = 4;
    localparam int unsigned NUM_REGS = 8;

    // Header byte layout: [7:5] sync, [4] auto-increment, [3] reserved, [2:0] address.
    localparam int unsigned HDR_SYNC_MSB = 7;
    localparam int unsigned HDR_SYNC_LSB = 5;
    localparam int unsigned HDR_AINC_BIT = 4;
    localparam int unsigned HDR_ADDR_MSB = 2;
    localparam int unsigned HDR_ADDR_LSB = 0;

    localparam logic [2:0] SYNC_PAT = 3'b101;

    // reg_3 of each pulse channel; writes here restart the channel.
    localparam logic [ADDR_W-1:0] ADDR_P1_R3 = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_P2_R3 = 3'd7;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

endpackage

// File: rtl/apu_frame_timer.sv
// Inter-byte timeout counter for host-link frame parsers.
module apu_frame_timer #(
    parameter int unsigned TIMEOUT = 5000,
    parameter int unsigned TMR_W   = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             expired_q, expired_d;

    // Clear wins over enable; expired flags a count of TIMEOUT-1.
    always_comb begin
        tmr_d = tmr_q;
        if (clear) begin
            tmr_d = '0;
        end else if (enable) begin
            tmr_d = tmr_q + TMR_W'(1);
        end
        expired_d = (tmr_d == TMR_W'(TIMEOUT - 1));
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/apu_reg_writer.sv
// Decodes framed UART bytes into pulse channel register writes.
module apu_reg_writer
    import apu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 5000,
    parameter int unsigned TMR_W   = 13
) (
    input  logic              apu_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] p1_reg_0,
    output logic [DATA_W-1:0] p1_reg_1,
    output logic [DATA_W-1:0] p1_reg_2,
    output logic [DATA_W-1:0] p1_reg_3,
    output logic [DATA_W-1:0] p2_reg_0,
    output logic [DATA_W-1:0] p2_reg_1,
    output logic [DATA_W-1:0] p2_reg_2,
    output logic [DATA_W-1:0] p2_reg_3,
    output logic              p1_change,
    output logic              p2_change,
    output logic              busy,
    output logic [ERR_W-1:0]  err_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ainc_q, ainc_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              p1_change_q, p1_change_d;
    logic              p2_change_q, p2_change_d;
    logic              busy_q, busy_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              tmr_clear, tmr_en, tmr_expired;

    apu_frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk     (apu_clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    // Frame parser: header decode, data writes, toggles, timeout abandon.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ainc_d      = ainc_q;
        regs_d      = regs_q;
        p1_change_d = p1_change_q;
        p2_change_d = p2_change_q;
        err_d       = err_q;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == SYNC_PAT) begin
                        addr_d    = rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                        ainc_d    = rx_data[HDR_AINC_BIT];
                        tmr_clear = 1'b1;
                        state_d   = WAIT_DATA;
                    end else if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
            end
            WAIT_DATA: begin
                // A byte on the expiry cycle still counts as data.
                if (rx_valid) begin
                    regs_d[addr_q] = rx_data;
                    if (addr_q == ADDR_P1_R3) p1_change_d = ~p1_change_q;
                    if (addr_q == ADDR_P2_R3) p2_change_d = ~p2_change_q;
                    if (ainc_q) begin
                        addr_d    = addr_q + ADDR_W'(1);
                        tmr_clear = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmr_expired) begin
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WAIT_DATA);
    end

    // Parser state, register bank and status flops.
    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ainc_q      <= 1'b0;
            p1_change_q <= 1'b0;
            p2_change_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ainc_q      <= ainc_d;
            p1_change_q <= p1_change_d;
            p2_change_q <= p2_change_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign p1_reg_0  = regs_q[0];
    assign p1_reg_1  = regs_q[1];
    assign p1_reg_2  = regs_q[2];
    assign p1_reg_3  = regs_q[3];
    assign p2_reg_0  = regs_q[4];
    assign p2_reg_1  = regs_q[5];
    assign p2_reg_2  = regs_q[6];
    assign p2_reg_3  = regs_q[7];
    assign p1_change = p1_change_q;
    assign p2_change = p2_change_q;
    assign busy      = busy_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_apu_reg_writer.sv
// Self-checking bench for apu_reg_writer.
module tb_apu_reg_writer;

    localparam int TIMEOUT = 5000;
    localparam int TMR_W   = 13;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_busy;
        logic [3:0] e_err;
        logic       e_p1c;
        logic       e_p2c;
        int         ridx;   // register written by this vector, -1 for none
        logic [7:0] e_reg;
    } vec_t;

    logic       apu_clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] p1_reg_0, p1_reg_1, p1_reg_2, p1_reg_3;
    logic [7:0] p2_reg_0, p2_reg_1, p2_reg_2, p2_reg_3;
    logic       p1_change, p2_change, busy;
    logic [3:0] err_count;

    apu_reg_writer #(.TIMEOUT(TIMEOUT), .TMR_W(TMR_W)) dut (
        .apu_clk   (apu_clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .p1_reg_0  (p1_reg_0),
        .p1_reg_1  (p1_reg_1),
        .p1_reg_2  (p1_reg_2),
        .p1_reg_3  (p1_reg_3),
        .p2_reg_0  (p2_reg_0),
        .p2_reg_1  (p2_reg_1),
        .p2_reg_2  (p2_reg_2),
        .p2_reg_3  (p2_reg_3),
        .p1_change (p1_change),
        .p2_change (p2_change),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 apu_clk = ~apu_clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    vec_t       sb[$];
    vec_t       tbl[16];
    logic [7:0] sh_regs[8];
    logic       sh_busy, sh_p1c, sh_p2c;
    logic [3:0] sh_err;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic b,
                                input logic [3:0] e, input logic c1, input logic c2,
                                input int ridx, input logic [7:0] r);
        vec_t x;
        x.v = v; x.d = d; x.e_busy = b; x.e_err = e;
        x.e_p1c = c1; x.e_p2c = c2; x.ridx = ridx; x.e_reg = r;
        return x;
    endfunction

    task automatic check(input string name);
        logic [7:0] got[8];
        got = '{p1_reg_0, p1_reg_1, p1_reg_2, p1_reg_3, p2_reg_0, p2_reg_1, p2_reg_2, p2_reg_3};
        n_vec++;
        if (busy !== sh_busy) begin
            n_miss++; $display("FAIL %s busy got %0b want %0b", name, busy, sh_busy);
        end
        if (err_count !== sh_err) begin
            n_miss++; $display("FAIL %s err_count got %0d want %0d", name, err_count, sh_err);
        end
        if (p1_change !== sh_p1c) begin
            n_miss++; $display("FAIL %s p1_change got %0b want %0b", name, p1_change, sh_p1c);
        end
        if (p2_change !== sh_p2c) begin
            n_miss++; $display("FAIL %s p2_change got %0b want %0b", name, p2_change, sh_p2c);
        end
        for (int i = 0; i < 8; i++) begin
            if (got[i] !== sh_regs[i]) begin
                n_miss++;
                $display("FAIL %s reg%0d got %02h want %02h", name, i, got[i], sh_regs[i]);
            end
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 8; i++) sh_regs[i] = 8'h00;
        sh_busy = 1'b0; sh_err = 4'd0; sh_p1c = 1'b0; sh_p2c = 1'b0;
    endtask

    // Drive one cycle of stimulus; expectation is queued and retired after the edge.
    task automatic apply(input vec_t x, input string name);
        vec_t e;
        @(negedge apu_clk);
        rx_valid = x.v;
        rx_data  = x.d;
        sb.push_back(x);
        @(posedge apu_clk);
        #1;
        rx_valid = 1'b0;
        e = sb.pop_front();
        sh_busy = e.e_busy; sh_err = e.e_err; sh_p1c = e.e_p1c; sh_p2c = e.e_p2c;
        if (e.ridx >= 0) sh_regs[e.ridx] = e.e_reg;
        check(name);
    endtask

    // n idle cycles inside an open frame; busy drops after the cycle numbered drop_at.
    task automatic idle_run(input int n, input int drop_at, input string name);
        for (int k = 1; k <= n; k++) begin
            apply(mk(1'b0, 8'h00, (k < drop_at), sh_err, sh_p1c, sh_p2c, -1, 8'h00),
                  $sformatf("%s_k%0d", name, k));
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 8'hA3, 1, 0, 0, 0, -1, 8'h00);
        tbl[1]  = mk(1, 8'h5C, 0, 0, 1, 0,  3, 8'h5C);
        tbl[2]  = mk(0, 8'h00, 0, 0, 1, 0, -1, 8'h00);
        tbl[3]  = mk(1, 8'hB0, 1, 0, 1, 0, -1, 8'h00);
        tbl[4]  = mk(1, 8'h11, 1, 0, 1, 0,  0, 8'h11);
        tbl[5]  = mk(1, 8'h22, 1, 0, 1, 0,  1, 8'h22);
        tbl[6]  = mk(1, 8'h33, 1, 0, 1, 0,  2, 8'h33);
        tbl[7]  = mk(1, 8'h44, 1, 0, 0, 0,  3, 8'h44);
        tbl[8]  = mk(1, 8'h55, 1, 0, 0, 0,  4, 8'h55);
        tbl[9]  = mk(1, 8'h66, 1, 0, 0, 0,  5, 8'h66);
        tbl[10] = mk(1, 8'h77, 1, 0, 0, 0,  6, 8'h77);
        tbl[11] = mk(1, 8'h88, 1, 0, 0, 1,  7, 8'h88);
        tbl[12] = mk(1, 8'h99, 1, 0, 0, 1,  0, 8'h99);
        tbl[13] = mk(1, 8'h00, 0, 1, 0, 1, -1, 8'h00);
        tbl[14] = mk(1, 8'hFF, 0, 2, 0, 1, -1, 8'h00);
        tbl[15] = mk(1, 8'h43, 0, 3, 0, 1, -1, 8'h00);

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        clear_shadow();
        #12;
        check("reset");
        @(negedge apu_clk);
        rst_n = 1'b1;

        // Single write, then auto-increment burst wrapping past address 7.
        for (int i = 0; i <= 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        idle_run(TIMEOUT, TIMEOUT, "burst_to");

        // Bad headers, then saturation of the error counter.
        for (int i = 13; i <= 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));
        for (int i = 0; i < 20; i++) begin
            apply(mk(1, 8'(i), 0, ((3 + i + 1) > 15) ? 4'd15 : 4'(3 + i + 1), 0, 1, -1, 8'h00),
                  $sformatf("bad%0d", i));
        end

        // Abandoned frame: the late byte opens a new frame at address 0.
        apply(mk(1, 8'hA1, 1, 15, 0, 1, -1, 8'h00), "to_hdr");
        idle_run(TIMEOUT, TIMEOUT, "to_wait");
        apply(mk(1, 8'hA0, 1, 15, 0, 1, -1, 8'h00), "to_newhdr");
        apply(mk(1, 8'h7E, 0, 15, 0, 1,  0, 8'h7E), "to_newdata");

        // Data strobe on the expiry cycle is still accepted.
        apply(mk(1, 8'hA5, 1, 15, 0, 1, -1, 8'h00), "exp_hdr");
        idle_run(TIMEOUT - 1, TIMEOUT, "exp_wait");
        apply(mk(1, 8'h3C, 0, 15, 0, 1,  5, 8'h3C), "exp_data");

        // Write to p2 reg_3 without auto-increment toggles p2_change only.
        apply(mk(1, 8'hA7, 1, 15, 0, 1, -1, 8'h00), "p2r3_hdr");
        apply(mk(1, 8'hC3, 0, 15, 0, 0,  7, 8'hC3), "p2r3_data");

        // Asynchronous reset between header and data.
        apply(mk(1, 8'hA3, 1, 15, 0, 0, -1, 8'h00), "rst_hdr");
        @(negedge apu_clk);
        #2;
        rst_n = 1'b0;
        #1;
        clear_shadow();
        check("rst_async");
        #3;
        rst_n = 1'b1;
        apply(mk(1, 8'h5C, 0, 1, 0, 0, -1, 8'h00), "rst_after");
        apply(mk(1, 8'hB6, 1, 1, 0, 0, -1, 8'h00), "rst_hdr2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
